// File: rtl/hazard_stall_unit_if.sv
// Decode-stage hazard/stall bundle between the ID stage and hazard_stall_unit.
// The master drives the decoded ID instruction and stall sources; the slave returns the controls.
interface hazard_stall_unit_if;

    logic [15:0] instruction_in;
    logic        ReadingRs_in;
    logic        ReadingRt_in;
    logic        RegWrite_in;
    logic [2:0]  WriteReg_in;
    logic        MemToReg_in;
    logic        BranchingOrJumping_in;
    logic        instructionMemoryStall_in;
    logic        dataMemoryStall_in;

    logic        stall;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        flush_ifid;

    modport master (
        output instruction_in,
        output ReadingRs_in,
        output ReadingRt_in,
        output RegWrite_in,
        output WriteReg_in,
        output MemToReg_in,
        output BranchingOrJumping_in,
        output instructionMemoryStall_in,
        output dataMemoryStall_in,
        input  stall,
        input  pc_en,
        input  ifid_en,
        input  idex_en,
        input  flush_ifid
    );

    modport slave (
        input  instruction_in,
        input  ReadingRs_in,
        input  ReadingRt_in,
        input  RegWrite_in,
        input  WriteReg_in,
        input  MemToReg_in,
        input  BranchingOrJumping_in,
        input  instructionMemoryStall_in,
        input  dataMemoryStall_in,
        output stall,
        output pc_en,
        output ifid_en,
        output idex_en,
        output flush_ifid
    );

endinterface

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard and stall controller: two-slot scoreboard of in-flight writers (EX, MEM)
// plus a branch-resolution wait FSM, producing bubble and pipeline-register enables.
module hazard_stall_unit #(
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned BR_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave hs
);

    typedef enum logic [0:0] {
        StRun,
        StBrWait
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic       load;
    } slot_t;

    localparam logic [2:0] BrCount = 3'(BR_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    slot_t      s0_q, s0_d;
    slot_t      s1_q, s1_d;

    logic [2:0] rs;
    logic [2:0] rt;
    logic       match0;
    logic       match1;
    logic       hazard;
    logic       last_wait;

    logic       stall;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       flush_ifid;

    assign rs = hs.instruction_in[10:8];
    assign rt = hs.instruction_in[7:5];

    assign match0 = s0_q.valid & ((hs.ReadingRs_in & (s0_q.rd == rs)) |
                                  (hs.ReadingRt_in & (s0_q.rd == rt)));
    assign match1 = s1_q.valid & ((hs.ReadingRs_in & (s1_q.rd == rs)) |
                                  (hs.ReadingRt_in & (s1_q.rd == rt)));

    // With forwarding only a load still in EX cannot be bypassed in time.
    assign hazard = FWD_EN ? (match0 & s0_q.load) : (match0 | match1);

    // Treat a zero count as final too, so the FSM can never wrap and wait forever.
    assign last_wait = (cnt_q <= 3'd1);

    always_comb begin
        stall      = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        flush_ifid = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;

        if (hs.dataMemoryStall_in) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else if (state_q == StBrWait) begin
            stall      = 1'b1;
            flush_ifid = 1'b1;
            pc_en      = last_wait;
            cnt_d      = cnt_q - 3'd1;
            if (last_wait) begin
                state_d = StRun;
            end
        end else if (hs.instructionMemoryStall_in) begin
            stall = 1'b1;
            pc_en = 1'b0;
        end else if (hazard) begin
            stall   = 1'b1;
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (hs.BranchingOrJumping_in) begin
            state_d = StBrWait;
            cnt_d   = BrCount;
        end
    end

    // A bubble enters EX as an invalid writer; a frozen cycle holds everything.
    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (!hs.dataMemoryStall_in) begin
            s1_d = s0_q;
            s0_d = '{valid: hs.RegWrite_in & ~stall,
                     rd:    hs.WriteReg_in,
                     load:  hs.MemToReg_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
            s0_q    <= '0;
            s1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    assign hs.stall      = stall;
    assign hs.pc_en      = pc_en;
    assign hs.ifid_en    = ifid_en;
    assign hs.idex_en    = idex_en;
    assign hs.flush_ifid = flush_ifid;

    logic unused_bits;
    assign unused_bits = ^{hs.instruction_in[15:11], hs.instruction_in[4:0], s1_q.load};

endmodule
